// File: rtl/fpu_sequencer.sv
// Sequences one FP command at a time: to an external handshake unit, or to the internal compare path.
// Compare/illegal respond one cycle after accept; unit ops bounded by a TIMEOUT-cycle watchdog; resp held until resp_ready.
module fpu_sequencer #(
  parameter int NUM_UNITS = 5,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic [31:0]            unit_a,
  output logic [31:0]            unit_b,
  output logic [NUM_UNITS-1:0]   unit_in_stb,
  input  logic [NUM_UNITS-1:0]   unit_in_ack,
  input  logic [32*NUM_UNITS-1:0] unit_out,
  input  logic [NUM_UNITS-1:0]   unit_out_stb,
  output logic [NUM_UNITS-1:0]   unit_out_ack
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] unit_a_q, unit_a_d;
  logic [31:0] unit_b_q, unit_b_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        dec_unit, dec_cmp, dec_illegal;
  logic [2:0]  dec_idx;
  logic        cmp_res, both_zero, any_nan, eq, lt;

  logic [NUM_UNITS-1:0] sel_oh;
  logic        sel_in_ack, sel_out_stb;
  logic [31:0] sel_out_dat;

  always_comb begin
    dec_unit    = 1'b0;
    dec_cmp     = 1'b0;
    dec_illegal = 1'b0;
    dec_idx     = 3'd0;
    case (req_op)
      4'd0, 4'd1: begin dec_unit = 1'b1; dec_idx = 3'd0; end
      4'd2:       begin dec_unit = 1'b1; dec_idx = 3'd1; end
      4'd3:       begin dec_unit = 1'b1; dec_idx = 3'd2; end
      4'd4:       begin dec_unit = 1'b1; dec_idx = 3'd3; end
      4'd5:       begin dec_unit = 1'b1; dec_idx = 3'd4; end
      4'd6, 4'd7, 4'd8: dec_cmp = 1'b1;
      default:    dec_illegal = 1'b1;
    endcase
    // Ops whose unit is not present in this configuration are illegal.
    if (dec_unit && (int'(dec_idx) >= NUM_UNITS)) begin
      dec_unit    = 1'b0;
      dec_illegal = 1'b1;
    end
  end

  // Sign-magnitude ordering; +0 and -0 compare equal, NaN makes every compare false.
  always_comb begin
    both_zero = (req_a[30:0] == 31'd0) && (req_b[30:0] == 31'd0);
    any_nan   = ((req_a[30:23] == 8'hFF) && (req_a[22:0] != 23'd0)) ||
                ((req_b[30:23] == 8'hFF) && (req_b[22:0] != 23'd0));
    eq        = both_zero || (req_a == req_b);
    if (req_a[31] != req_b[31]) begin
      lt = req_a[31] && !both_zero;
    end else if (!req_a[31]) begin
      lt = req_a[30:0] < req_b[30:0];
    end else begin
      lt = req_a[30:0] > req_b[30:0];
    end
    case (req_op)
      4'd6:    cmp_res = eq;
      4'd7:    cmp_res = lt;
      default: cmp_res = lt || eq;
    endcase
    if (any_nan || !dec_cmp) begin
      cmp_res = 1'b0;
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_in_ack  = 1'b0;
    sel_out_stb = 1'b0;
    sel_out_dat = 32'd0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (idx_q == 3'(k)) begin
        sel_oh[k]   = 1'b1;
        sel_in_ack  = unit_in_ack[k];
        sel_out_stb = unit_out_stb[k];
        sel_out_dat = unit_out[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          idx_d    = dec_idx;
          unit_a_d = req_a;
          // fsub reuses the adder with b negated.
          unit_b_d = (req_op == 4'd1) ? {~req_b[31], req_b[30:0]} : req_b;
          if (dec_unit) begin
            state_d = SEND;
            cnt_d   = 16'd0;
          end else begin
            state_d     = RESP;
            resp_data_d = {31'd0, cmp_res};
            resp_err_d  = dec_illegal;
          end
        end
      end
      SEND: begin
        if (sel_in_ack) begin
          state_d = WAIT;
          cnt_d   = cnt_q + 16'd1;
        end else if (cnt_q >= TMO_LAST) begin
          state_d     = RESP;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT: begin
        if (sel_out_stb) begin
          state_d     = RESP;
          resp_data_d = sel_out_dat;
          resp_err_d  = 1'b0;
        end else if (cnt_q >= TMO_LAST) begin
          state_d     = RESP;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      unit_a_q    <= 32'd0;
      unit_b_q    <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Gated by reset_n so no command is accepted while reset is held.
  assign req_ready    = (state_q == IDLE) && reset_n;
  assign resp_valid   = (state_q == RESP);
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign unit_a       = unit_a_q;
  assign unit_b       = unit_b_q;
  assign unit_in_stb  = (state_q == SEND) ? sel_oh : '0;
  assign unit_out_ack = (state_q == WAIT) ? sel_oh : '0;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed self-checking bench for fpu_sequencer: unit routing, compares, illegal ops, timeout, backpressure, reset.
module tb_fpu_sequencer;
  localparam int NU  = 5;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [3:0]      req_op;
  logic [31:0]     req_a, req_b, resp_data, unit_a, unit_b;
  logic [NU-1:0]   unit_in_stb, unit_in_ack, unit_out_stb, unit_out_ack;
  logic [32*NU-1:0] unit_out;

  logic            req_valid3, req_ready3, resp_valid3, resp_ready3, resp_err3;
  logic [3:0]      req_op3;
  logic [31:0]     resp_data3, unit_a3, unit_b3, zero32;
  logic [2:0]      unit_in_stb3, unit_out_ack3, zero3;
  logic [95:0]     zero96;

  int checks = 0;
  int errors = 0;

  // {op, a, b, expected}
  logic [68:0] cmp_vec [13] = '{
    {4'd6, 32'h00000000, 32'h80000000, 1'b1},
    {4'd7, 32'h7FC00000, 32'h3F800000, 1'b0},
    {4'd8, 32'h3F800000, 32'h3F800000, 1'b1},
    {4'd6, 32'h3F800000, 32'h3F800001, 1'b0},
    {4'd6, 32'h7FC00000, 32'h7FC00000, 1'b0},
    {4'd7, 32'hBF800000, 32'h3F800000, 1'b1},
    {4'd7, 32'h3F800000, 32'hBF800000, 1'b0},
    {4'd7, 32'hC0000000, 32'hBF800000, 1'b1},
    {4'd7, 32'h80000000, 32'h00000000, 1'b0},
    {4'd8, 32'h80000000, 32'h00000000, 1'b1},
    {4'd8, 32'h40000000, 32'h3F800000, 1'b0},
    {4'd8, 32'h3F800000, 32'h7F800001, 1'b0},
    {4'd7, 32'hFF800000, 32'h7F800000, 1'b1}
  };

  fpu_sequencer #(.NUM_UNITS(NU), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .unit_a(unit_a), .unit_b(unit_b), .unit_in_stb(unit_in_stb), .unit_in_ack(unit_in_ack),
    .unit_out(unit_out), .unit_out_stb(unit_out_stb), .unit_out_ack(unit_out_ack)
  );

  fpu_sequencer #(.NUM_UNITS(3), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3), .req_a(zero32), .req_b(zero32),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_data(resp_data3), .resp_err(resp_err3),
    .unit_a(unit_a3), .unit_b(unit_b3), .unit_in_stb(unit_in_stb3), .unit_in_ack(zero3),
    .unit_out(zero96), .unit_out_stb(zero3), .unit_out_ack(unit_out_ack3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pop();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    resp_ready = 1'b0; unit_in_ack = '0; unit_out_stb = '0; unit_out = '0;
    req_valid3 = 1'b0; req_op3 = 4'd0; resp_ready3 = 1'b0;
    zero32 = 32'd0; zero3 = 3'd0; zero96 = 96'd0;
    repeat (2) tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if ({resp_err, resp_data} !== 33'd0) begin errors++; $display("FAIL reset_resp: got %b/%h want 0/0", resp_err, resp_data); end
    checks++; if ({unit_in_stb, unit_out_ack} !== '0) begin errors++; $display("FAIL reset_stb_ack: got %b/%b want 0/0", unit_in_stb, unit_out_ack); end
    checks++; if ({unit_a, unit_b} !== 64'd0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", unit_a, unit_b); end
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_fadd();
    tick();
    issue(4'd0, 32'h3F800000, 32'h40000000);
    checks++; if (unit_in_stb !== 5'b00001) begin errors++; $display("FAIL fadd_stb: got %b want 00001", unit_in_stb); end
    checks++; if ({unit_a, unit_b} !== {32'h3F800000, 32'h40000000}) begin errors++; $display("FAIL fadd_operands: got %h/%h want 3f800000/40000000", unit_a, unit_b); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fadd_busy_ready: got %b want 0", req_ready); end
    unit_out[31:0] = 32'h12345678; unit_out_stb = 5'b00001;
    tick();
    unit_out_stb = '0;
    checks++; if (unit_in_stb !== 5'b00001 || resp_valid !== 1'b0) begin errors++; $display("FAIL fadd_stb_hold: got %b/%b want 00001/0", unit_in_stb, resp_valid); end
    unit_in_ack = 5'b00001;
    tick();
    unit_in_ack = '0;
    checks++; if ({unit_in_stb, unit_out_ack} !== {5'b00000, 5'b00001}) begin errors++; $display("FAIL fadd_wait: got %b/%b want 00000/00001", unit_in_stb, unit_out_ack); end
    unit_out[63:32] = 32'hDEADBEEF; unit_out_stb = 5'b00010;
    tick();
    unit_out_stb = '0;
    checks++; if (resp_valid !== 1'b0 || unit_out_ack !== 5'b00001) begin errors++; $display("FAIL fadd_foreign_stb: got %b/%b want 0/00001", resp_valid, unit_out_ack); end
    unit_out[31:0] = 32'h40400000; unit_out_stb = 5'b00001;
    tick();
    unit_out_stb = '0; unit_out = '0;
    checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, 32'h40400000}) begin errors++; $display("FAIL fadd_resp: got %b/%b/%h want 1/0/40400000", resp_valid, resp_err, resp_data); end
    checks++; if (unit_out_ack !== '0) begin errors++; $display("FAIL fadd_ack_drop: got %b want 0", unit_out_ack); end
    pop();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL fadd_pop: got %b/%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_fsub();
    issue(4'd1, 32'h40400000, 32'h3F800000);
    checks++; if (unit_in_stb !== 5'b00001) begin errors++; $display("FAIL fsub_stb: got %b want 00001", unit_in_stb); end
    checks++; if ({unit_a, unit_b} !== {32'h40400000, 32'hBF800000}) begin errors++; $display("FAIL fsub_operands: got %h/%h want 40400000/bf800000", unit_a, unit_b); end
    unit_in_ack = 5'b00001;
    tick();
    unit_in_ack = '0; unit_out[31:0] = 32'h40000000; unit_out_stb = 5'b00001;
    tick();
    unit_out_stb = '0;
    checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, 32'h40000000}) begin errors++; $display("FAIL fsub_resp: got %b/%b/%h want 1/0/40000000", resp_valid, resp_err, resp_data); end
    pop();
  endtask

  task automatic test_routing();
    logic [NU-1:0] exp_oh;
    logic [31:0]   val;
    for (int op = 2; op <= 5; op++) begin
      exp_oh = 5'b00001 << (op - 1);
      val    = 32'h11111111 * op;
      issue(4'(op), 32'hA5A5A5A5, 32'h5A5A5A5A);
      checks++; if (unit_in_stb !== exp_oh || unit_b !== 32'h5A5A5A5A) begin errors++; $display("FAIL route_stb op%0d: got %b/%h want %b/5a5a5a5a", op, unit_in_stb, unit_b, exp_oh); end
      unit_in_ack = exp_oh;
      tick();
      unit_in_ack = '0;
      checks++; if (unit_out_ack !== exp_oh) begin errors++; $display("FAIL route_ack op%0d: got %b want %b", op, unit_out_ack, exp_oh); end
      unit_out = '0; unit_out[32*(op-1) +: 32] = val; unit_out_stb = exp_oh;
      tick();
      unit_out_stb = '0;
      checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, val}) begin errors++; $display("FAIL route_resp op%0d: got %b/%b/%h want 1/0/%h", op, resp_valid, resp_err, resp_data, val); end
      pop();
    end
    unit_out = '0;
  endtask

  task automatic test_compare();
    logic [68:0] v;
    for (int i = 0; i < 13; i++) begin
      v = cmp_vec[i];
      issue(v[68:65], v[64:33], v[32:1]);
      checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, 31'd0, v[0]}) begin errors++; $display("FAIL cmp[%0d] op%0d %h,%h: got %b/%b/%h want 1/0/%0d", i, v[68:65], v[64:33], v[32:1], resp_valid, resp_err, resp_data, v[0]); end
      checks++; if (unit_in_stb !== '0) begin errors++; $display("FAIL cmp_stb[%0d]: got %b want 0", i, unit_in_stb); end
      pop();
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3] = '{4'd9, 4'd11, 4'd15};
    for (int i = 0; i < 3; i++) begin
      issue(bad[i], 32'h3F800000, 32'h3F800000);
      checks++; if ({resp_valid, resp_err, resp_data} !== {2'b11, 32'd0}) begin errors++; $display("FAIL illegal op%0d: got %b/%b/%h want 1/1/0", bad[i], resp_valid, resp_err, resp_data); end
      checks++; if (unit_in_stb !== '0) begin errors++; $display("FAIL illegal_stb op%0d: got %b want 0", bad[i], unit_in_stb); end
      pop();
    end
    for (int op = 4; op <= 5; op++) begin
      req_valid3 = 1'b1; req_op3 = 4'(op);
      tick();
      req_valid3 = 1'b0;
      checks++; if ({resp_valid3, resp_err3, resp_data3, unit_in_stb3} !== {2'b11, 32'd0, 3'd0}) begin errors++; $display("FAIL absent_unit op%0d: got %b/%b/%h/%b want 1/1/0/000", op, resp_valid3, resp_err3, resp_data3, unit_in_stb3); end
      resp_ready3 = 1'b1;
      tick();
      resp_ready3 = 1'b0;
      checks++; if ({resp_valid3, req_ready3} !== 2'b01) begin errors++; $display("FAIL absent_unit_pop op%0d: got %b/%b want 0/1", op, resp_valid3, req_ready3); end
    end
  endtask

  task automatic test_timeout(input bit ack_first);
    issue(4'd3, 32'h40000000, 32'h3F800000);
    if (ack_first) unit_in_ack = 5'b00100;
    for (int i = 1; i <= TMO; i++) begin
      tick();
      unit_in_ack = '0;
      if (i < TMO) begin
        checks++; if (resp_valid !== 1'b0 || (unit_in_stb | unit_out_ack) !== 5'b00100) begin errors++; $display("FAIL tmo_pending ack%0d cyc%0d: got %b/%b/%b want 0, unit 2 selected", ack_first, i, resp_valid, unit_in_stb, unit_out_ack); end
      end else begin
        checks++; if ({resp_valid, resp_err, resp_data} !== {2'b11, 32'd0}) begin errors++; $display("FAIL tmo_resp ack%0d: got %b/%b/%h want 1/1/0", ack_first, resp_valid, resp_err, resp_data); end
        checks++; if ({unit_in_stb, unit_out_ack} !== '0) begin errors++; $display("FAIL tmo_drop ack%0d: got %b/%b want 0/0", ack_first, unit_in_stb, unit_out_ack); end
      end
    end
    pop();
    tick();
    checks++; if ({resp_valid, unit_in_stb, unit_out_ack} !== '0) begin errors++; $display("FAIL tmo_after ack%0d: got %b/%b/%b want 0", ack_first, resp_valid, unit_in_stb, unit_out_ack); end
  endtask

  task automatic test_backpressure();
    issue(4'd8, 32'h3F800000, 32'h3F800000);
    req_valid = 1'b1; req_op = 4'd6; req_a = 32'h0; req_b = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({resp_valid, resp_err, resp_data, req_ready} !== {2'b10, 32'd1, 1'b0}) begin errors++; $display("FAIL bp_hold cyc%0d: got %b/%b/%h/%b want 1/0/1/0", i, resp_valid, resp_err, resp_data, req_ready); end
      tick();
    end
    req_valid = 1'b0;
    pop();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b/%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'd6; req_a = 32'h00000000; req_b = 32'h80000000;
    tick();
    req_op = 4'd7; req_a = 32'h3F800000; req_b = 32'hBF800000;
    checks++; if ({resp_valid, resp_data, req_ready} !== {1'b1, 32'd1, 1'b0}) begin errors++; $display("FAIL b2b_first: got %b/%h/%b want 1/1/0", resp_valid, resp_data, req_ready); end
    tick();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle: got %b/%b want 0/1", resp_valid, req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if ({resp_valid, resp_data} !== {1'b1, 32'd0}) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/0", resp_valid, resp_data); end
    tick();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b want 0", resp_valid); end
  endtask

  task automatic test_reset_mid();
    issue(4'd0, 32'h3F800000, 32'h3F800000);
    unit_in_ack = 5'b00001;
    tick();
    unit_in_ack = '0;
    checks++; if (unit_out_ack !== 5'b00001) begin errors++; $display("FAIL rstmid_wait: got %b want 00001", unit_out_ack); end
    reset_n = 1'b0;
    #1;
    checks++; if ({resp_valid, req_ready, unit_in_stb, unit_out_ack} !== '0 || unit_a !== 32'd0) begin errors++; $display("FAIL rstmid_async: got %b/%b/%b/%b/%h want all 0", resp_valid, req_ready, unit_in_stb, unit_out_ack, unit_a); end
    unit_out[31:0] = 32'h40000000; unit_out_stb = 5'b00001;
    tick();
    unit_out_stb = '0; unit_out = '0;
    reset_n = 1'b1;
    #1;
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_release: got %b/%b want 0/1", resp_valid, req_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_idle cyc%0d: got %b/%b want 0/1", i, resp_valid, req_ready); end
    end
    issue(4'd8, 32'h3F800000, 32'h40000000);
    checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, 32'd1}) begin errors++; $display("FAIL rstmid_next: got %b/%b/%h want 1/0/1", resp_valid, resp_err, resp_data); end
    pop();
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fsub();
    test_routing();
    test_compare();
    test_illegal();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
